// File: rtl/pwm_capture_if.sv
// pwm_capture_if: Avalon-MM register bus between a host (master) and the PWM capture slave
interface pwm_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, read, write, writedata, input readdata);
  modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period/high time and floored duty percent; define PWM_CAPTURE_IRQ_EN for the irq output
module pwm_capture #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  pwm_capture_if.slave bus,
  input  logic         pwm_in,
  output logic         irq
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DIVIDE} state_t;
  state_t      state_q;
  logic        s1_q, s2_q, prev_q;
  logic        en_q, new_q, timeout_q, valid_q, irq_en_q;
  logic [31:0] per_cnt_q, high_cnt_q, period_q, high_q, rdata_q, rd_mux;
  logic [31:0] per_inc, high_inc, rem_q;
  logic [7:0]  duty_q, quo_q;
  logic [38:0] dvd_q;
  logic [32:0] rem_sh, diff;
  logic [5:0]  iter_q;
  logic        rise, wr_ctrl, en_d, unused_wdata;
  assign rise         = s2_q & ~prev_q;
  assign wr_ctrl      = bus.chipselect & bus.write & (bus.address == 2'd3);
  assign en_d         = wr_ctrl ? bus.writedata[0] : en_q;
  assign per_inc      = &per_cnt_q ? per_cnt_q : per_cnt_q + 32'd1;
  assign high_inc     = (s2_q && !(&high_cnt_q)) ? high_cnt_q + 32'd1 : high_cnt_q;
  assign rem_sh       = {rem_q, dvd_q[38]};
  assign diff         = rem_sh - {1'b0, period_q};
  assign unused_wdata = ^bus.writedata[31:2];
  assign rd_mux = bus.address == 2'd0 ? {valid_q, 23'd0, duty_q} :
                  bus.address == 2'd1 ? period_q :
                  bus.address == 2'd2 ? high_q :
                  {28'd0, irq_en_q, timeout_q, new_q, en_q};
  assign bus.readdata = rdata_q;
  // synchronizer, control register, measurement FSM and restoring divider (diff[32] set means remainder < divisor)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      en_q       <= 1'b0;
      new_q      <= 1'b0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      duty_q     <= '0;
      quo_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      iter_q     <= '0;
    end else begin
      s1_q   <= pwm_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      en_q   <= en_d;
      if (wr_ctrl && bus.writedata[1]) new_q <= 1'b0;
      if (!en_d) begin
        state_q    <= IDLE;
        per_cnt_q  <= '0;
        high_cnt_q <= '0;
      end else case (state_q)
        IDLE: state_q <= ARM;
        ARM: if (rise) begin
          per_cnt_q  <= 32'd1;
          high_cnt_q <= 32'd1;
          state_q    <= MEASURE;
        end
        MEASURE: if (rise) begin
          period_q   <= per_cnt_q;
          high_q     <= high_cnt_q;
          dvd_q      <= {7'd0, high_cnt_q} * 39'd100;
          rem_q      <= '0;
          iter_q     <= '0;
          per_cnt_q  <= 32'd1;
          high_cnt_q <= 32'd1;
          state_q    <= DIVIDE;
        end else if (per_cnt_q == TIMEOUT_CYCLES) begin
          timeout_q <= 1'b1;
          new_q     <= 1'b1;
          duty_q    <= s2_q ? 8'd100 : 8'd0;
          valid_q   <= 1'b1;
          period_q  <= '0;
          high_q    <= '0;
          state_q   <= ARM;
        end else begin
          per_cnt_q  <= per_inc;
          high_cnt_q <= high_inc;
        end
        DIVIDE: begin
          per_cnt_q  <= rise ? 32'd1 : per_inc;
          high_cnt_q <= rise ? 32'd1 : high_inc;
          if (iter_q == 6'd39) begin
            duty_q    <= quo_q;
            valid_q   <= 1'b1;
            new_q     <= 1'b1;
            timeout_q <= 1'b0;
            state_q   <= MEASURE;
          end else begin
            rem_q  <= diff[32] ? rem_sh[31:0] : diff[31:0];
            quo_q  <= {quo_q[6:0], ~diff[32]};
            dvd_q  <= {dvd_q[37:0], 1'b0};
            iter_q <= iter_q + 6'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  // registered read data, zero whenever no qualified read
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdata_q <= '0;
    else rdata_q <= (bus.chipselect & bus.read) ? rd_mux : 32'd0;
`ifdef PWM_CAPTURE_IRQ_EN
  logic irq_q;
  assign irq = irq_q;
  // interrupt enable bit and level interrupt, one cycle behind NEW
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= bus.writedata[3];
      irq_q <= new_q & irq_en_q;
    end
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table-driven and directed checks of the PWM capture slave
module tb_pwm_capture;
  localparam logic [31:0] TO = 32'd2000;
  typedef struct {
    int unsigned period;
    int unsigned high;
    logic [31:0] duty;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pwm_in;
  logic irq;
  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned gen_period = 100;
  int unsigned gen_high = 30;
  int unsigned ph = 0;
  logic [1:0] gen_mode = 2'd0;
  pwm_capture_if bus();
  pwm_capture #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .pwm_in(pwm_in), .irq(irq)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // waveform source: mode 0 low, 1 high, 2 periodic gen_high/gen_period
  initial forever begin
    @(negedge clk);
    if (gen_mode == 2'd2) begin
      pwm_in = ph < gen_high;
      ph = (ph + 1 >= gen_period) ? 0 : ph + 1;
    end else pwm_in = gen_mode[0];
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask
  task automatic expired(input string n);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", n);
  endtask
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write = 1'b0;
  endtask
  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.read = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read = 1'b0;
  endtask
  initial begin
    vec_t vecs[7];
    logic [31:0] d;
    int unsigned t1, t2, seen;
    bit found;
    vecs[0] = '{1000, 333, 32'h8000_0021};
    vecs[1] = '{41, 40, 32'h8000_0061};
    vecs[2] = '{200, 1, 32'h8000_0000};
    vecs[3] = '{77, 13, 32'h8000_0010};
    vecs[4] = '{64, 63, 32'h8000_0062};
    vecs[5] = '{20, 7, 32'h8000_0023};
    vecs[6] = '{250, 125, 32'h8000_0032};
    bus.address = 2'd0;
    bus.chipselect = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 32'd0);
    end
    gen_mode = 2'd2;
    bus_wr(2'd3, 32'h1);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      bus_rd(2'd1, d);
      found = (d == 32'd100);
    end
    t1 = cyc;
    if (!found) expired("period_poll");
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      bus_rd(2'd0, d);
      found = d[31];
    end
    t2 = cyc;
    if (!found) expired("duty_poll");
    chk("duty_latency", t2 - t1, 32'd40);
    chk("duty_100_30", d, 32'h8000_001E);
    bus_rd(2'd2, d);
    chk("high_100_30", d, 32'd30);
    bus_rd(2'd3, d);
    chk("ctrl_new", d, 32'h3);
    for (int i = 0; i < 7; i++) begin
      bus_wr(2'd3, 32'h0);
      gen_period = vecs[i].period;
      gen_high = vecs[i].high;
      bus_wr(2'd3, 32'h1);
      repeat (3 * vecs[i].period + 60) @(negedge clk);
      bus_rd(2'd1, d);
      chk($sformatf("v%0d_period", i), d, vecs[i].period);
      bus_rd(2'd2, d);
      chk($sformatf("v%0d_high", i), d, vecs[i].high);
      bus_rd(2'd0, d);
      chk($sformatf("v%0d_duty", i), d, vecs[i].duty);
    end
    bus_wr(2'd3, 32'h0);
    gen_mode = 2'd0;
    repeat (5) @(negedge clk);
    bus_wr(2'd3, 32'h1);
    repeat (5) @(negedge clk);
    gen_mode = 2'd1;
    repeat (2100) @(negedge clk);
    bus_rd(2'd3, d);
    chk("to_ctrl", d, 32'h7);
    bus_rd(2'd0, d);
    chk("to_duty", d, 32'h8000_0064);
    bus_rd(2'd1, d);
    chk("to_period", d, 32'd0);
    bus_rd(2'd2, d);
    chk("to_high", d, 32'd0);
    gen_period = 100;
    gen_high = 30;
    gen_mode = 2'd2;
    repeat (400) @(negedge clk);
    bus_rd(2'd3, d);
    chk("to_cleared", d & 32'h4, 32'h0);
    bus_rd(2'd0, d);
    chk("to_resample", d, 32'h8000_001E);
`ifdef PWM_CAPTURE_IRQ_EN
    bus_wr(2'd3, 32'hB);
    bus_rd(2'd3, d);
    chk("irq_en_rw", d & 32'h8, 32'h8);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = !irq;
    end
    if (!found) expired("irq_low");
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = irq;
    end
    if (!found) expired("irq_rise");
    bus_wr(2'd3, 32'hB);
    repeat (97) @(negedge clk);
    bus_wr(2'd3, 32'hB);
    bus_rd(2'd3, d);
    chk("w1c_set_wins", d & 32'h2, 32'h2);
    bus_wr(2'd3, 32'hB);
    @(negedge clk);
    chk("irq_drop", {31'd0, irq}, 32'd0);
`else
    bus_wr(2'd3, 32'hB);
    bus_rd(2'd3, d);
    chk("irq_en_ro", d & 32'h8, 32'h0);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (irq) seen++;
    end
    chk("irq_tied", seen, 32'd0);
`endif
    bus_wr(2'd3, 32'h3);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      bus_rd(2'd3, d);
      found = d[1];
    end
    if (!found) expired("new_poll");
    repeat (68) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_readdata", bus.readdata, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), d);
      chk($sformatf("mid_rst_reg%0d", a), d, 32'd0);
    end
    repeat (150) @(negedge clk);
    bus_rd(2'd0, d);
    chk("no_late_duty", d, 32'd0);
    bus_rd(2'd3, d);
    chk("still_idle", d, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
